// File: rtl/linebuf_pingpong_ctrl_if.sv
// Sink/source handshakes and FIFO strobes of the deinterlacer line-buffer scheduler.
// No latency of its own; the slave modport is the controller's view, master is the environment's.
// stall_cnt is present only when STALL_CNT_EN is defined.
interface linebuf_pingpong_ctrl_if #(
  parameter int LINES_PER_FIELD = 288
);
  localparam int LN_W = (LINES_PER_FIELD > 1) ? $clog2(LINES_PER_FIELD) : 1;

  logic            wr_pix;
  logic            wr_sop;
  logic            wr_ready;
  logic            wr_req0;
  logic            wr_req1;
  logic            rd_req0;
  logic            rd_req1;
  logic            empty_en0;
  logic            empty_en1;
  logic            rd_ready;
  logic            rd_avail;
  logic            q_valid;
  logic            q_sel;
  logic            q_sol;
  logic            q_eol;
  logic            q_sof;
  logic            q_eof;
  logic [LN_W-1:0] line_idx;
`ifdef STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  modport slave (
    input  wr_pix, wr_sop, rd_ready,
    output wr_ready, wr_req0, wr_req1, rd_req0, rd_req1, empty_en0, empty_en1,
    output rd_avail, q_valid, q_sel, q_sol, q_eol, q_sof, q_eof, line_idx
`ifdef STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport master (
    output wr_pix, wr_sop, rd_ready,
    input  wr_ready, wr_req0, wr_req1, rd_req0, rd_req1, empty_en0, empty_en1,
    input  rd_avail, q_valid, q_sel, q_sol, q_eol, q_sof, q_eof, line_idx
`ifdef STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/linebuf_pingpong_ctrl.sv
// Ping-pong scheduler for two line FIFOs: steers sink pixels, grants source reads, emits line/field markers.
// Strobes are combinational in the handshake cycle; q_* markers are registered (1 cycle, FIFO read latency).
// wr_ready drops while the write buffer holds an undrained line or on an abort; optional STALL_CNT_EN adds stall_cnt.
module linebuf_pingpong_ctrl #(
  parameter int LINE_LEN        = 720,
  parameter int LINES_PER_FIELD = 288
) (
  input  logic                   clock,
  input  logic                   reset,
  linebuf_pingpong_ctrl_if.slave bus
);
  localparam int CNT_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LN_W  = (LINES_PER_FIELD > 1) ? $clog2(LINES_PER_FIELD) : 1;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(LINE_LEN - 1);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(LINES_PER_FIELD - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    READY    = 2'd2,
    DRAINING = 2'd3
  } buf_state_t;

  buf_state_t      st_q   [2];
  buf_state_t      st_nxt [2];
  logic            wsel;
  logic            rsel;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] rcnt;
  logic [1:0]      sof_flag;
  logic [LN_W-1:0] line_idx;

  logic            w_last;
  logic            r_last;
  logic            abort;
  logic            wr_ready;
  logic            accept;
  logic            rd_avail;
  logic            take;

  // Per-buffer occupancy state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_nxt[0];
      st_q[1] <= st_nxt[1];
    end
  end

  // Next occupancy state: write and read never touch the same buffer in one cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_nxt[b] = st_q[b];
      if (wsel == 1'(b)) begin
        if (abort) begin
          st_nxt[b] = EMPTY;
        end else if (accept) begin
          st_nxt[b] = w_last ? READY : FILLING;
        end
      end
      if (take && (rsel == 1'(b))) begin
        st_nxt[b] = r_last ? EMPTY : DRAINING;
      end
    end
  end

  // Handshake decode from registered state; everything held low while reset is asserted
  always_comb begin
    w_last   = (wcnt == PIX_LAST);
    r_last   = (rcnt == PIX_LAST);
    abort    = reset & bus.wr_pix & bus.wr_sop & (wcnt != '0);
    wr_ready = reset & ~abort & ((st_q[wsel] == EMPTY) || (st_q[wsel] == FILLING));
    accept   = bus.wr_pix & wr_ready;
    rd_avail = reset & ((st_q[rsel] == READY) || (st_q[rsel] == DRAINING));
    take     = rd_avail & bus.rd_ready;
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.wr_req0   = accept & ~wsel;
  assign bus.wr_req1   = accept & wsel;
  assign bus.empty_en0 = abort & ~wsel;
  assign bus.empty_en1 = abort & wsel;
  assign bus.rd_avail  = rd_avail;
  assign bus.rd_req0   = take & ~rsel;
  assign bus.rd_req1   = take & rsel;
  assign bus.line_idx  = line_idx;

  // Sink pixel counter, write buffer select and field-start flag latched on a line's first pixel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wsel     <= 1'b0;
      wcnt     <= '0;
      sof_flag <= '0;
    end else if (abort) begin
      wcnt <= '0;
    end else if (accept) begin
      if (st_q[wsel] == EMPTY) begin
        sof_flag[wsel] <= bus.wr_sop;
      end
      if (w_last) begin
        wcnt <= '0;
        wsel <= ~wsel;
      end else begin
        wcnt <= wcnt + CNT_W'(1);
      end
    end
  end

  // Source pixel counter and read buffer select
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsel <= 1'b0;
      rcnt <= '0;
    end else if (take) begin
      if (r_last) begin
        rcnt <= '0;
        rsel <= ~rsel;
      end else begin
        rcnt <= rcnt + CNT_W'(1);
      end
    end
  end

  // Registered markers aligned with FIFO q, plus the field line index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.q_valid <= 1'b0;
      bus.q_sel   <= 1'b0;
      bus.q_sol   <= 1'b0;
      bus.q_eol   <= 1'b0;
      bus.q_sof   <= 1'b0;
      bus.q_eof   <= 1'b0;
      line_idx    <= '0;
    end else begin
      bus.q_valid <= take;
      bus.q_sel   <= take & rsel;
      bus.q_sol   <= take & (rcnt == '0);
      bus.q_eol   <= take & r_last;
      bus.q_sof   <= take & (rcnt == '0) & sof_flag[rsel];
      bus.q_eof   <= take & r_last & (line_idx == LN_LAST);
      if (take && (rcnt == '0) && sof_flag[rsel]) begin
        line_idx <= '0;
      end else if (take && r_last) begin
        line_idx <= (line_idx == LN_LAST) ? '0 : line_idx + LN_W'(1);
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Saturating count of cycles the sink presented a pixel that was refused
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (bus.wr_pix && !wr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_linebuf_pingpong_ctrl.sv
// Bench for linebuf_pingpong_ctrl with LINE_LEN=4, LINES_PER_FIELD=2.
// Directed steps then random traffic, every cycle compared against a queue-of-lines model.
module tb_linebuf_pingpong_ctrl;
  localparam int LL  = 4;
  localparam int LPF = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  linebuf_pingpong_ctrl_if #(.LINES_PER_FIELD(LPF)) bus ();

  linebuf_pingpong_ctrl #(.LINE_LEN(LL), .LINES_PER_FIELD(LPF)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Observation vector bit positions
  localparam int B_WRDY = 14, B_WREQ0 = 13, B_WREQ1 = 12, B_EMP0 = 11, B_EMP1 = 10;
  localparam int B_AVAIL = 9, B_RREQ0 = 8, B_RREQ1 = 7, B_QV = 6, B_QSEL = 5;
  localparam int B_SOL = 4, B_EOL = 3, B_SOF = 2, B_EOF = 1, B_IDX = 0;

  logic [14:0] last_obs;

  // Reference model: completed lines awaiting readout, in write order
  typedef struct packed { logic b; logic sof; } line_t;
  line_t lines[$];
  logic  wbuf;
  int    fill;
  logic  fill_sof;
  int    rpos;
  int    idx;
  logic  qv, qs, qsol, qeol, qsof, qeof;

  function automatic logic [14:0] obs_vec();
    return {bus.wr_ready, bus.wr_req0, bus.wr_req1, bus.empty_en0, bus.empty_en1,
            bus.rd_avail, bus.rd_req0, bus.rd_req1, bus.q_valid, bus.q_valid & bus.q_sel,
            bus.q_sol, bus.q_eol, bus.q_sof, bus.q_eof, bus.line_idx[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    lines.delete();
    wbuf = 1'b0; fill = 0; fill_sof = 1'b0; rpos = 0; idx = 0;
    qv = 1'b0; qs = 1'b0; qsol = 1'b0; qeol = 1'b0; qsof = 1'b0; qeof = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model, pass the edge
  task automatic step(input logic pix, input logic sop, input logic rdy);
    logic abort, wrdy, acc, avail, take, hb, hs;
    logic [14:0] exp_v;
    bus.wr_pix = pix; bus.wr_sop = sop; bus.rd_ready = rdy;
    #1;
    abort = pix && sop && (fill > 0);
    wrdy  = (lines.size() < 2) && !abort;
    acc   = pix && wrdy;
    avail = lines.size() > 0;
    take  = avail && rdy;
    hb    = avail ? lines[0].b : 1'b0;
    hs    = avail ? lines[0].sof : 1'b0;
    exp_v = {wrdy, acc & ~wbuf, acc & wbuf, abort & ~wbuf, abort & wbuf, avail,
             take & ~hb, take & hb, qv, qs, qsol, qeol, qsof, qeof, (idx == 1)};
    last_obs = obs_vec();
    check("cycle", {17'd0, last_obs}, {17'd0, exp_v});
    qv   = take;
    qs   = take & hb;
    qsol = take && (rpos == 0);
    qeol = take && (rpos == LL - 1);
    qsof = qsol && hs;
    qeof = qeol && (idx == LPF - 1);
    if (take) begin
      if (rpos == 0 && hs) idx = 0;
      if (rpos == LL - 1) begin
        idx  = (idx + 1) % LPF;
        rpos = 0;
        lines.delete(0);
      end else begin
        rpos++;
      end
    end
    if (abort) fill = 0;
    if (acc) begin
      if (fill == 0) fill_sof = sop;
      fill++;
      if (fill == LL) begin
        lines.push_back('{b: wbuf, sof: fill_sof});
        wbuf = ~wbuf;
        fill = 0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int first_stall, first_avail, first_rdy;
    logic [31:0] m_rq0, m_rq1, m_sol, m_eol, m_qv, m_sof, m_eof, m_idx;

    reset = 1'b0;
    bus.wr_pix = 1'b0; bus.wr_sop = 1'b0; bus.rd_ready = 1'b0;
    model_reset();
    #3;
    check("reset_outputs", {17'd0, obs_vec()}, 32'd0);
    bus.wr_pix = 1'b1; bus.wr_sop = 1'b1; bus.rd_ready = 1'b1;
    #1;
    check("reset_outputs_inputs_high", {17'd0, obs_vec()}, 32'd0);
    @(posedge clock);
    #1;
    bus.wr_pix = 1'b0; bus.wr_sop = 1'b0; bus.rd_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("post_reset_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("post_reset_rd_avail", {31'd0, bus.rd_avail}, 32'd0);

    // Continuous write of 10 pixels with the source stalled
    first_stall = -1; first_avail = -1; m_rq0 = 0; m_rq1 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      m_rq0[i] = last_obs[B_WREQ0];
      m_rq1[i] = last_obs[B_WREQ1];
      if (first_stall < 0 && !last_obs[B_WRDY]) first_stall = i;
      if (first_avail < 0 && last_obs[B_AVAIL]) first_avail = i;
    end
    check("wr_req0_pixels", m_rq0, 32'h00F);
    check("wr_req1_pixels", m_rq1, 32'h0F0);
    check("first_stall_pixel", first_stall, 32'd8);
    check("first_avail_pixel", first_avail, 32'd4);

    // Read both lines out
    first_rdy = -1; m_rq0 = 0; m_rq1 = 0; m_sol = 0; m_eol = 0; m_qv = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1);
      m_rq0[i] = last_obs[B_RREQ0];
      m_rq1[i] = last_obs[B_RREQ1];
      m_sol[i] = last_obs[B_SOL];
      m_eol[i] = last_obs[B_EOL];
      m_qv[i]  = last_obs[B_QV];
      if (first_rdy < 0 && last_obs[B_WRDY]) first_rdy = i;
    end
    check("rd_req0_reads", m_rq0, 32'h00F);
    check("rd_req1_reads", m_rq1, 32'h0F0);
    check("q_valid_follow", m_qv, 32'h1FE);
    check("q_sol_reads", m_sol, 32'h022);
    check("q_eol_reads", m_eol, 32'h110);
    check("wr_ready_rise", first_rdy, 32'd4);

    // Field markers
    for (int i = 0; i < 8; i++) step(1'b1, (i == 0), 1'b0);
    m_sof = 0; m_eof = 0; m_idx = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1);
      m_sof[i] = last_obs[B_SOF];
      m_eof[i] = last_obs[B_EOF];
      m_idx[i] = last_obs[B_IDX];
    end
    check("q_sof_reads", m_sof, 32'h002);
    check("q_eof_reads", m_eof, 32'h100);
    check("line_idx_seq", m_idx, 32'h0F0);

    // Abort after two accepted pixels
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("abort_wr_ready", {31'd0, last_obs[B_WRDY]}, 32'd0);
    check("abort_empty_en0", {31'd0, last_obs[B_EMP0]}, 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("abort_retry_wr_req0", {31'd0, last_obs[B_WREQ0]}, 32'd1);
    check("abort_pulse_ends", {31'd0, last_obs[B_EMP0]}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_line_complete", {31'd0, last_obs[B_AVAIL]}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    bus.wr_pix = 1'b1; bus.wr_sop = 1'b1; bus.rd_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("reset_midtraffic", {17'd0, obs_vec()}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("midreset_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("midreset_rd_avail", {31'd0, bus.rd_avail}, 32'd0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);

`ifdef STALL_CNT_EN
    reset = 1'b0;
    #2;
    check("stall_cnt_reset", {16'd0, bus.stall_cnt}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("stall_cnt_5", {16'd0, bus.stall_cnt}, 32'd5);
    bus.wr_pix = 1'b1; bus.wr_sop = 1'b0; bus.rd_ready = 1'b0;
    repeat (70000) @(posedge clock);
    #1;
    check("stall_cnt_saturate", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
